// File: rtl/display_scan_controller.sv
// display_scan_controller: 4-digit 7-segment scan with frame-aligned value commit.
// Define LEADING_ZERO_BLANK_EN to blank digits above the most-significant non-zero nibble.
module display_scan_controller #(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int CNT_W           = 17
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        enableIn,
    input  logic [15:0] valueIn,
    input  logic        loadValid,
    output logic        loadReady,
    output logic [1:0]  digitSelect,
    output logic [3:0]  nibbleOut,
    output logic        blankOut,
    output logic        frameStart
);
    typedef enum logic {IDLE, PENDING} state_t;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_presc;
    logic [1:0]       r_digit;
    logic [15:0]      r_shadow, r_displayed;
    logic             r_frame_start;
    logic             w_tick, w_commit, w_load, w_apply;

    assign w_tick   = enableIn && (r_presc == CNT_W'(TICKS_PER_DIGIT - 1));
    assign w_commit = w_tick && (r_digit == 2'd3);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_presc       <= '0;
            r_digit       <= 2'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_commit;
            if (enableIn) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) r_digit <= r_digit + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_shadow    <= 16'h0000;
            r_displayed <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) r_shadow <= valueIn;
            if (w_apply) r_displayed <= r_shadow;
        end
    end

    // A load taken while IDLE in a commit cycle waits for the following wrap.
    always_comb begin
        w_state_nxt = r_state;
        loadReady   = 1'b0;
        w_load      = 1'b0;
        w_apply     = 1'b0;
        if (r_state == IDLE) begin
            loadReady = 1'b1;
            w_load    = loadValid;
            if (loadValid) w_state_nxt = PENDING;
        end else if (w_commit) begin
            w_apply     = 1'b1;
            w_state_nxt = IDLE;
        end
    end

    assign digitSelect = r_digit;
    assign nibbleOut   = r_displayed[4*r_digit +: 4];
    assign frameStart  = r_frame_start;

`ifdef LEADING_ZERO_BLANK_EN
    logic [1:0] w_msd;
    always_comb begin
        w_msd = 2'd0;
        for (int i = 1; i < 4; i++)
            if (r_displayed[4*i +: 4] != 4'd0) w_msd = 2'(i);
    end
    assign blankOut = !enableIn || (r_digit > w_msd);
`else
    assign blankOut = !enableIn;
`endif
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed and random stimulus against a cycle-count reference model.
module tb_display_scan_controller;
    localparam int T = 4;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        enableIn = 1'b1;
    logic [15:0] valueIn = 16'h0000;
    logic        loadValid = 1'b0;
    logic        loadReady, blankOut, frameStart;
    logic [1:0]  digitSelect;
    logic [3:0]  nibbleOut;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: elapsed enabled cycles, committed value, pending load
    int          m_n;
    logic [15:0] m_disp, m_shadow;
    bit          m_pend, m_fs;

    display_scan_controller #(.TICKS_PER_DIGIT(T), .CNT_W(3)) dut (
        .clk(clk), .resetN(resetN), .enableIn(enableIn), .valueIn(valueIn),
        .loadValid(loadValid), .loadReady(loadReady), .digitSelect(digitSelect),
        .nibbleOut(nibbleOut), .blankOut(blankOut), .frameStart(frameStart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_n = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 0; m_fs = 0;
    endfunction

    function automatic int m_digit();
        return (m_n / T) % 4;
    endfunction

    function automatic bit m_blank();
        int msd = 0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 1; k < 4; k++) if (((m_disp >> (4*k)) & 16'hF) != 0) msd = k;
        return !enableIn || (m_digit() > msd);
`else
        return !enableIn;
`endif
    endfunction

    function automatic bit m_commit_next();
        return enableIn && (m_n % (4*T) == 4*T - 1);
    endfunction

    function automatic void m_step();
        bit c = m_commit_next();
        m_fs = c;
        if (m_pend && c) begin
            m_disp = m_shadow; m_pend = 0;
        end else if (!m_pend && loadValid) begin
            m_shadow = valueIn; m_pend = 1;
        end
        if (enableIn) m_n++;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".digit"}, 32'(digitSelect), 32'(m_digit()));
        chk({tag, ".nibble"}, 32'(nibbleOut), 32'((m_disp >> (4*m_digit())) & 16'hF));
        chk({tag, ".ready"}, 32'(loadReady), 32'(!m_pend));
        chk({tag, ".frame"}, 32'(frameStart), 32'(m_fs));
        chk({tag, ".blank"}, 32'(blankOut), 32'(m_blank()));
    endtask

    task automatic cyc(input bit en, input bit v, input logic [15:0] val, input string tag);
        enableIn = en; loadValid = v; valueIn = val;
        @(posedge clk);
        m_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic run_to_commit_edge(input string tag);
        int guard = 0;
        while (!(m_n % (4*T) == 4*T - 1) && guard < 100) begin
            cyc(1, 0, 16'h0, tag);
            guard++;
        end
        if (guard >= 100) chk({tag, ".timeout"}, 32'(guard), 32'(0));
    endtask

    initial begin
        m_reset();
        #12;
        enableIn = 1'b1;
        check_all("reset");
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1, 0, 16'h0, "scan");
        while (m_digit() != 1) cyc(1, 0, 16'h0, "to_d1");
        cyc(1, 1, 16'hA5C3, "loadA5C3");
        for (int i = 0; i < 36; i++) cyc(1, 0, 16'h0, "showA5C3");
        cyc(1, 1, 16'h1234, "load1234");
        for (int i = 0; i < 20; i++) cyc(1, 1, 16'hFFFF, "offerFFFF");
        loadValid = 1'b0;
        for (int i = 0; i < 20; i++) cyc(1, 0, 16'h0, "drain");
        run_to_commit_edge("align");
        cyc(1, 1, 16'h0042, "load_on_commit");
        for (int i = 0; i < 40; i++) cyc(1, 0, 16'h0, "after_commit_load");
        while (m_digit() != 2) cyc(1, 0, 16'h0, "to_d2");
        for (int i = 0; i < 10; i++) cyc(0, 0, 16'h0, "disabled");
        for (int i = 0; i < 20; i++) cyc(1, 0, 16'h0, "resume");
        cyc(1, 1, 16'h0000, "load0000");
        for (int i = 0; i < 36; i++) cyc(1, 0, 16'h0, "show0000");
        cyc(1, 1, 16'hBEEF, "loadBEEF");
        for (int i = 0; i < 5; i++) cyc(1, 0, 16'h0, "pend");
        enableIn = 1'b1; loadValid = 1'b0;
        #2 resetN = 1'b0;
        #1 m_reset();
        check_all("async_reset");
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 40; i++) cyc(1, 0, 16'h0, "post_reset");
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] v = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, v, "rand");
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
